main_memory: RTL and testbench

Word-addressed main memory responder that sits on the memory side of the cache controller and answers its memory-bus handshake (`MStrobe`, `MRW`, address, write data). Each access is held for a configurable number of wait states, then completed with a one-cycle `MReady` pulse. This gives the cache a realistic miss/write-through penalty. The block holds the backing array, a wait-state down-counter and a three-state responder FSM.

---
 rtl/main_memory_if.sv | 24 ++
 rtl/main_memory.sv | 128 ++++++++++++
 tb/tb_main_memory.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/main_memory_if.sv
// Memory-side bus between the cache controller (master) and main_memory (slave).
interface main_memory_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              MStrobe;
   logic              MRW;
   logic [ADDR_W-1:0] MAddr;
   logic [DATA_W-1:0] MDataIn;
   logic [DATA_W-1:0] MDataOut;
   logic              MReady;
   logic              MBusy;
   logic              MErr;

   modport master (
      output MStrobe, MRW, MAddr, MDataIn,
      input  MDataOut, MReady, MBusy, MErr
   );

   modport slave (
      input  MStrobe, MRW, MAddr, MDataIn,
      output MDataOut, MReady, MBusy, MErr
   );
endinterface

// File: rtl/main_memory.sv
// Word-addressed main memory responder with WAIT wait states per access.
// Define MEM_ERR_EN to flag out-of-range addresses instead of wrapping them.
//
// state   | meaning
// ST_IDLE | waiting for MStrobe; captures request on acceptance
// ST_WAIT | counting down wait states
// ST_DONE | MReady cycle; array read/write takes effect at the closing edge
module main_memory #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int WAIT   = 4
) (
   input logic           clk,
   input logic           reset,
   main_memory_if.slave  bus
);
   localparam int         IDX_W  = $clog2(DEPTH);
   localparam logic [7:0] WAIT_L = 8'(WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t            state;
   logic [7:0]        cnt;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ready_q;
   logic              busy_q;
   logic              acc_err;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;

   logic [DATA_W-1:0] mem [DEPTH];

   assign idx     = addr_q[IDX_W-1:0];
   assign rd_word = acc_err ? '0 : mem[idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.MStrobe) begin
                  rw_q    <= bus.MRW;
                  addr_q  <= bus.MAddr;
                  wdata_q <= bus.MDataIn;
                  cnt     <= WAIT_L;
                  busy_q  <= 1'b1;
                  if (WAIT_L == 8'd0) begin
                     state   <= ST_DONE;
                     ready_q <= 1'b1;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state   <= ST_DONE;
                  ready_q <= 1'b1;
               end
            end
            ST_DONE: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               if (rw_q)
                  rdata_q <= rd_word;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Reset forces ST_IDLE, so an aborted write can never reach this port.
   always_ff @(posedge clk) begin
      if (state == ST_DONE && !rw_q && !acc_err)
         mem[idx] <= wdata_q;
   end

`ifdef MEM_ERR_EN
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic in_bad;
   logic err_q;
   logic merr_q;

   assign in_bad = {1'b0, bus.MAddr} >= DEPTH_X;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q  <= 1'b0;
         merr_q <= 1'b0;
      end else begin
         if (state == ST_IDLE && bus.MStrobe) begin
            err_q  <= in_bad;
            merr_q <= (WAIT_L == 8'd0) ? in_bad : 1'b0;
         end else if (state == ST_WAIT && cnt == 8'd1) begin
            merr_q <= err_q;
         end else if (state == ST_DONE) begin
            merr_q <= 1'b0;
         end
      end
   end

   assign acc_err = err_q;
   assign bus.MErr = merr_q;
`else
   assign acc_err = 1'b0;
   assign bus.MErr = 1'b0;
`endif

   // Read data is visible during DONE so the cache can sample it on the MReady edge.
   assign bus.MDataOut = (state == ST_DONE && rw_q) ? rd_word : rdata_q;
   assign bus.MReady   = ready_q;
   assign bus.MBusy    = busy_q;
endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: one instance with WAIT=4/DEPTH=256, one with WAIT=0/DEPTH=128.
module tb_main_memory;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;

   main_memory_if #(.ADDR_W(8), .DATA_W(32)) bus4 ();
   main_memory_if #(.ADDR_W(8), .DATA_W(32)) bus0 ();

   main_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT(4)) u_mem4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   main_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT(0)) u_mem0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // sel=1 drives the WAIT=0 instance. Returns at the negedge of the MReady cycle.
   task automatic acc(input bit sel, input logic rw, input logic [7:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] q, output logic e);
      @(negedge clk);
      if (sel) begin
         bus0.MStrobe = 1'b1; bus0.MRW = rw; bus0.MAddr = a; bus0.MDataIn = d;
      end else begin
         bus4.MStrobe = 1'b1; bus4.MRW = rw; bus4.MAddr = a; bus4.MDataIn = d;
      end
      @(negedge clk);
      bus0.MStrobe = 1'b0;
      bus4.MStrobe = 1'b0;
      lat = 0; q = '0; e = 1'b0;
      for (int n = 1; n < 40; n++) begin
         if (sel ? bus0.MReady : bus4.MReady) begin
            lat = n;
            q   = sel ? bus0.MDataOut : bus4.MDataOut;
            e   = sel ? bus0.MErr : bus4.MErr;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] q;
      logic        e;

      n_vec = 0;
      n_bad = 0;
      reset = 1'b0;
      bus4.MStrobe = 1'b0; bus4.MRW = 1'b0; bus4.MAddr = '0; bus4.MDataIn = '0;
      bus0.MStrobe = 1'b0; bus0.MRW = 1'b0; bus0.MAddr = '0; bus0.MDataIn = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus4.MReady), 32'd0);
      chk("rst_busy",  32'(bus4.MBusy),  32'd0);
      chk("rst_dout",  bus4.MDataOut,    32'd0);
      reset = 1'b1;

      // Write then read back through the WAIT=4 instance
      acc(1'b0, 1'b0, 8'd5, 32'h0000_0011, lat, q, e);
      chk("wr_lat", 32'(lat), 32'd5);
      acc(1'b0, 1'b1, 8'd5, 32'h0, lat, q, e);
      chk("rd_lat", 32'(lat), 32'd5);
      chk("rd_data", q, 32'h0000_0011);

      // Write to an idle-read location keeps the old read value through its DONE
      acc(1'b0, 1'b0, 8'd10, 32'hA5A5_A5A5, lat, q, e);
      chk("wr_hold_done", q, 32'h0000_0011);
      @(negedge clk);
      chk("wr_hold_after", bus4.MDataOut, 32'h0000_0011);
      acc(1'b0, 1'b1, 8'd10, 32'h0, lat, q, e);
      chk("rd10_done", q, 32'hA5A5_A5A5);
      @(negedge clk);
      chk("rd10_held", bus4.MDataOut, 32'hA5A5_A5A5);

      // Reset mid-WAIT
      acc(1'b0, 1'b0, 8'd3, 32'hDEAD_BEEF, lat, q, e);
      @(negedge clk);
      bus4.MStrobe = 1'b1; bus4.MRW = 1'b1; bus4.MAddr = 8'd3;
      @(negedge clk);
      bus4.MStrobe = 1'b0;
      @(negedge clk);
      chk("midwait_busy", 32'(bus4.MBusy), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_ready", 32'(bus4.MReady), 32'd0);
      chk("abort_busy",  32'(bus4.MBusy),  32'd0);
      chk("abort_err",   32'(bus4.MErr),   32'd0);
      chk("abort_dout",  bus4.MDataOut,    32'd0);
      @(negedge clk);
      reset = 1'b1;
      acc(1'b0, 1'b1, 8'd3, 32'h0, lat, q, e);
      chk("rerd_lat", 32'(lat), 32'd5);
      chk("rerd_data", q, 32'hDEAD_BEEF);

      // Mid-access input changes with strobe held high
      acc(1'b0, 1'b0, 8'd20, 32'h0000_0020, lat, q, e);
      acc(1'b0, 1'b0, 8'd21, 32'h0000_0021, lat, q, e);
      @(negedge clk);
      bus4.MStrobe = 1'b1; bus4.MRW = 1'b1; bus4.MAddr = 8'd20;
      @(negedge clk);
      @(negedge clk);
      bus4.MAddr = 8'd21;
      lat = 0;
      for (int n = 2; n < 40; n++) begin
         if (bus4.MReady) begin lat = n; break; end
         @(negedge clk);
      end
      chk("hold_lat1", 32'(lat), 32'd5);
      chk("hold_data1", bus4.MDataOut, 32'h0000_0020);
      @(negedge clk);
      chk("hold_idle_busy", 32'(bus4.MBusy), 32'd0);
      @(negedge clk);
      chk("hold_acc2_busy", 32'(bus4.MBusy), 32'd1);
      lat = 0;
      for (int n = 7; n < 40; n++) begin
         if (bus4.MReady) begin lat = n; break; end
         @(negedge clk);
      end
      bus4.MStrobe = 1'b0;
      chk("hold_lat2", 32'(lat), 32'd11);
      chk("hold_data2", bus4.MDataOut, 32'h0000_0021);

      // Back-to-back on WAIT=0 with strobe held: write then read address 0
      @(negedge clk);
      @(negedge clk);
      bus0.MStrobe = 1'b1; bus0.MRW = 1'b0; bus0.MAddr = 8'd0; bus0.MDataIn = 32'h1;
      @(negedge clk);
      chk("b2b_rdy_c1", 32'(bus0.MReady), 32'd1);
      bus0.MRW = 1'b1;
      @(negedge clk);
      chk("b2b_rdy_c2", 32'(bus0.MReady), 32'd0);
      @(negedge clk);
      chk("b2b_rdy_c3", 32'(bus0.MReady), 32'd1);
      chk("b2b_data", bus0.MDataOut, 32'h1);
      bus0.MStrobe = 1'b0;

      // Out-of-range addressing, DEPTH=128
`ifdef MEM_ERR_EN
      acc(1'b1, 1'b0, 8'd72, 32'h0000_0077, lat, q, e);
      acc(1'b1, 1'b1, 8'd200, 32'h0, lat, q, e);
      chk("err_rd_lat", 32'(lat), 32'd1);
      chk("err_rd_flag", 32'(e), 32'd1);
      chk("err_rd_data", q, 32'd0);
      acc(1'b1, 1'b0, 8'd200, 32'h0000_0055, lat, q, e);
      chk("err_wr_flag", 32'(e), 32'd1);
      acc(1'b1, 1'b1, 8'd72, 32'h0, lat, q, e);
      chk("err_a72_data", q, 32'h0000_0077);
      chk("err_a72_flag", 32'(e), 32'd0);
`else
      acc(1'b1, 1'b0, 8'd200, 32'h0000_0055, lat, q, e);
      chk("wrap_wr_flag", 32'(e), 32'd0);
      acc(1'b1, 1'b1, 8'd72, 32'h0, lat, q, e);
      chk("wrap_rd_lat", 32'(lat), 32'd1);
      chk("wrap_rd_data", q, 32'h0000_0055);
      chk("wrap_rd_flag", 32'(e), 32'd0);
      acc(1'b1, 1'b1, 8'd200, 32'h0, lat, q, e);
      chk("wrap_rd200", q, 32'h0000_0055);
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
